ripple_count_checker: RTL and testbench

Downstream consumer and self-checker for the 4-bit ripple-carry counter output. It samples the counter value `q` on every rising edge of `clk`; the counter updates on the falling edge, so `q` has half a cycle to settle. It verifies that each sample is exactly the previous sample plus one, modulo 2^WIDTH. It reports wrap events, keeps a wrap tally, and flags sequence faults with a sticky error and a saturating fault counter.

---
 rtl/ripple_count_checker_pkg.sv | 14 +
 rtl/ripple_count_checker_sat_counter.sv | 23 ++
 rtl/ripple_count_checker.sv | 86 ++++++++
 tb/tb_ripple_count_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ripple_count_checker_pkg.sv
// Shared definitions for the ripple counter checker.
// State encoding and default widths.
package ripple_count_checker_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WRAP_W = 8;
  localparam int DEF_ERR_W  = 4;

  // 2'd3 is unused and decodes as SYNC
  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

endpackage

// File: rtl/ripple_count_checker_sat_counter.sv
// Saturating counter with synchronous clear.
// Clear is applied before a same-cycle increment.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ripple_count_checker.sv
// Samples a falling-edge counter on posedge clk and checks
// that every sample is the previous one plus one.
module ripple_count_checker
  import ripple_count_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  q,
  input  logic              clr_err,
  output logic              wrap,
  output logic [WRAP_W-1:0] wraps,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              locked
);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] exp_q;
  logic             match;
  logic             fault;
  logic             wrap_n;

  assign exp_q = prev + WIDTH'(1);
  assign match = (q == exp_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SYNC;
    end else begin
      state <= state_n;
    end
  end

  // SYNC and FAULT both just capture and move on
  always_comb begin
    state_n = RUN;
    unique case (1'b1)
      (state == RUN): state_n = match ? RUN : FAULT;
      default:        state_n = RUN;
    endcase
  end

  always_comb begin
    fault  = 1'b0;
    wrap_n = 1'b0;
    if (state == RUN) begin
      fault  = !match;
      wrap_n = match && (prev == '1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= '0;
      wrap   <= 1'b0;
      wraps  <= '0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else begin
      prev   <= q;
      wrap   <= wrap_n;
      err    <= fault | (err & ~clr_err);
      locked <= (state_n == RUN);
      if (wrap_n) begin
        wraps <= wraps + WRAP_W'(1);
      end
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_err),
    .inc   (fault),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_ripple_count_checker.sv
// Randomised bench for ripple_count_checker.
// Reference model tracks the checker at the sample level.
module tb_ripple_count_checker;

  logic       clk;
  logic       reset;
  logic [3:0] q;
  logic       clr_err;
  logic       wrap;
  logic [7:0] wraps;
  logic       err;
  logic [3:0] err_cnt;
  logic       locked;

  int n_cmp;
  int n_bad;

  // reference model
  bit m_chk;
  int m_prev;
  int m_wraps;
  bit m_wrap;
  bit m_err;
  int m_cnt;
  int cq;

  ripple_count_checker dut (
    .clk     (clk),
    .reset   (reset),
    .q       (q),
    .clr_err (clr_err),
    .wrap    (wrap),
    .wraps   (wraps),
    .err     (err),
    .err_cnt (err_cnt),
    .locked  (locked)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".wrap"}, int'(wrap), int'(m_wrap));
    chk({tag, ".wraps"}, int'(wraps), m_wraps);
    chk({tag, ".err"}, int'(err), int'(m_err));
    chk({tag, ".err_cnt"}, int'(err_cnt), m_cnt);
    chk({tag, ".locked"}, int'(locked), int'(m_chk));
  endtask

  task automatic m_reset();
    m_chk   = 0;
    m_prev  = 0;
    m_wraps = 0;
    m_wrap  = 0;
    m_err   = 0;
    m_cnt   = 0;
  endtask

  // one clock: drive at negedge, model at posedge, check at negedge
  task automatic step(input int qv, input bit c, input string tag);
    int e;
    bit f;
    bit w;
    qv      = qv % 16;
    q       = 4'(qv);
    clr_err = c;
    @(posedge clk);
    e = (m_prev + 1) % 16;
    f = m_chk && (qv != e);
    w = m_chk && (qv == e) && (qv == 0);
    if (w) m_wraps = (m_wraps + 1) % 256;
    if (c) begin
      m_err = 0;
      m_cnt = 0;
    end
    if (f) begin
      m_err = 1;
      if (m_cnt < 15) m_cnt++;
    end
    m_chk  = !f;
    m_prev = qv;
    m_wrap = w;
    @(negedge clk);
    clr_err = 1'b0;
    chk_all(tag);
  endtask

  task automatic good(input string tag);
    cq = (cq + 1) % 16;
    step(cq, 1'b0, tag);
  endtask

  // replace the true value with a wrong one; the counter keeps going
  task automatic glitch(input int v, input bit c, input string tag);
    cq = (cq + 1) % 16;
    step(v, c, tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    m_reset();
    chk_all(tag);
    @(negedge clk);
    reset = 1'b0;
    chk_all({tag, ".held"});
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    cq      = 0;
    reset   = 1'b1;
    q       = 4'h0;
    clr_err = 1'b0;
    m_reset();
    #1;
    chk_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // free run: capture 0, then count, several wraps
    step(cq, 1'b0, "sync");
    for (int i = 0; i < 40; i++) good("free");
    chk("free.wraps_seen", int'(wraps), 2);

    // glitch: 9 where 5 is due
    while (((cq + 1) % 16) != 5) good("pre_glitch");
    glitch(9, 1'b0, "glitch");
    chk("glitch.locked_low", int'(locked), 0);
    for (int i = 0; i < 6; i++) good("post_glitch");

    // 0 where 8 is due must not count as a wrap
    while (((cq + 1) % 16) != 8) good("pre_w0");
    glitch(0, 1'b0, "fault_at_0");
    chk("fault_at_0.nowrap", int'(wrap), 0);
    for (int i = 0; i < 4; i++) good("post_w0");

    // saturation by alternating 3 / C
    for (int i = 0; i < 40; i++) begin
      step((i % 2 == 0) ? 3 : 12, 1'b0, "sat");
    end
    chk("sat.max", int'(err_cnt), 15);
    cq = (m_prev + 1) % 16;
    step(cq, 1'b1, "clr");
    chk("clr.err_cnt", int'(err_cnt), 0);
    for (int i = 0; i < 3; i++) good("post_clr");

    // five faults, then clear together with a sixth
    for (int i = 0; i < 5; i++) begin
      glitch((cq + 1 + $urandom_range(1, 15)) % 16, 1'b0, "pre5");
      good("pre5.r");
      good("pre5.g");
    end
    chk("pre5.cnt", int'(err_cnt), 5);
    glitch((cq + 1 + $urandom_range(1, 15)) % 16, 1'b1, "clr_fault");
    chk("clr_fault.cnt", int'(err_cnt), 1);
    for (int i = 0; i < 3; i++) good("post_cf");

    // mid-run reset near E with a wrap already counted
    while (cq != 14) good("pre_rst");
    mid_reset("mid_rst");
    step(cq, 1'b0, "rst_sync");
    for (int i = 0; i < 20; i++) good("rst_run");

    // random mix
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        glitch((cq + 1 + $urandom_range(1, 15)) % 16,
               $urandom_range(0, 3) == 0, "rnd_bad");
      end else if (r < 13) begin
        cq = (cq + 1) % 16;
        step(cq, 1'b1, "rnd_clr");
      end else if (r < 15) begin
        mid_reset("rnd_rst");
        cq = $urandom_range(0, 15);
        step(cq, 1'b0, "rnd_sync");
      end else begin
        good("rnd_good");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
